// File: rtl/btn_evt_pkg.sv
// Shared encodings for the button event sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package btn_evt_pkg;

    // FSM state encoding, 2 bits wide.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS1 = 2'd1,
        WAIT2  = 2'd2,
        HOLD   = 2'd3
    } state_e;

    // Event code used internally to pick at most one pulse per cycle.
    typedef enum logic [1:0] {
        EVT_NONE   = 2'd0,
        EVT_SHORT  = 2'd1,
        EVT_LONG   = 2'd2,
        EVT_DOUBLE = 2'd3
    } evt_e;

endpackage

// File: rtl/tick_counter.sv
// Tick-qualified counter with sync clear and a terminal-count strobe.
// Latency: term is combinational from cnt/tick; cnt updates one clock later.
// Backpressure: none; tick is a free-running strobe.
//
// Ports: clk/rst (async active-low), clr (sync clear, wins over tick),
//        tick (count enable), limit (terminal value), term (cnt==limit-1 && tick).
module tick_counter #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             tick,
    input  logic [CNT_W-1:0] limit,
    output logic             term
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign term = tick && (cnt == (limit - CNT_W'(1)));

endmodule

// File: rtl/btn_event_ctrl.sv
// Turns a debounced button level into short/long/double-click pulses.
// Latency: each pulse is registered, one clock after its qualifying edge/tick.
// Backpressure: none; pulses are fire-and-forget, one clock wide.
//
// Ports: clk_100Mhz, rst (async active-low), tick (1 ms strobe), btn_db (level),
//        short_press / long_press / double_click (pulses), busy (state != IDLE).
// Optional build macro BTN_EVT_REPEAT_EN: long_press auto-repeats every
// REPEAT_MS ticks while a long press is held.
module btn_event_ctrl
    import btn_evt_pkg::*;
#(
    parameter int LONG_MS   = 1000,
    parameter int DCLICK_MS = 300,
`ifdef BTN_EVT_REPEAT_EN
    parameter int REPEAT_MS = 200,
`endif
    parameter int CNT_W     = 11
) (
    input  logic clk_100Mhz,
    input  logic rst,
    input  logic tick,
    input  logic btn_db,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic busy
);

    localparam logic [CNT_W-1:0] LONG_LIM   = CNT_W'(LONG_MS);
    localparam logic [CNT_W-1:0] DCLICK_LIM = CNT_W'(DCLICK_MS);
`ifdef BTN_EVT_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LIM = CNT_W'(REPEAT_MS);
`endif

    logic btn_q;
    logic primed;
    logic rise;
    logic fall;

    state_e           state;
    state_e           state_nxt;
    evt_e             evt_nxt;
    logic             cnt_clr;
    logic [CNT_W-1:0] limit;
    logic             term;

`ifdef BTN_EVT_REPEAT_EN
    logic rep_flag;
    logic rep_flag_nxt;
`endif

    // btn_q comes out of reset as 0; primed masks the first cycle after reset
    // so a button already held across reset is not mistaken for a fresh press.
    always_ff @(posedge clk_100Mhz or negedge rst) begin
        if (!rst) begin
            btn_q  <= 1'b0;
            primed <= 1'b0;
        end else begin
            btn_q  <= btn_db;
            primed <= 1'b1;
        end
    end

    assign rise = primed &  btn_db & ~btn_q;
    assign fall = primed & ~btn_db &  btn_q;

    tick_counter #(
        .CNT_W (CNT_W)
    ) u_tick_counter (
        .clk   (clk_100Mhz),
        .rst   (rst),
        .clr   (cnt_clr),
        .tick  (tick),
        .limit (limit),
        .term  (term)
    );

    always_comb begin
        state_nxt = state;
        evt_nxt   = EVT_NONE;
        cnt_clr   = 1'b0;
        limit     = LONG_LIM;
`ifdef BTN_EVT_REPEAT_EN
        rep_flag_nxt = rep_flag;
`endif
        case (state)
            IDLE: begin
                // Nothing to time here; hold the counter at zero.
                cnt_clr = 1'b1;
                if (rise) begin
                    state_nxt = PRESS1;
                end
            end
            PRESS1: begin
                limit = LONG_LIM;
                // Release wins over a coincident final tick.
                if (fall) begin
                    state_nxt = WAIT2;
                end else if (term) begin
                    evt_nxt   = EVT_LONG;
                    state_nxt = HOLD;
`ifdef BTN_EVT_REPEAT_EN
                    rep_flag_nxt = 1'b1;
`endif
                end
            end
            WAIT2: begin
                limit = DCLICK_LIM;
                // Second press wins over a coincident final tick.
                if (rise) begin
                    evt_nxt   = EVT_DOUBLE;
                    state_nxt = HOLD;
`ifdef BTN_EVT_REPEAT_EN
                    rep_flag_nxt = 1'b0;
`endif
                end else if (term) begin
                    evt_nxt   = EVT_SHORT;
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
`ifdef BTN_EVT_REPEAT_EN
                limit = REPEAT_LIM;
                if (fall) begin
                    state_nxt = IDLE;
                end else if (!rep_flag) begin
                    cnt_clr = 1'b1;
                end else if (term && btn_db) begin
                    // Restart the repeat period after each re-pulse.
                    evt_nxt = EVT_LONG;
                    cnt_clr = 1'b1;
                end
`else
                cnt_clr = 1'b1;
                if (fall) begin
                    state_nxt = IDLE;
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (state_nxt != state) begin
            cnt_clr = 1'b1;
        end
    end

    always_ff @(posedge clk_100Mhz or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            short_press  <= (evt_nxt == EVT_SHORT);
            long_press   <= (evt_nxt == EVT_LONG);
            double_click <= (evt_nxt == EVT_DOUBLE);
            busy         <= (state_nxt != IDLE);
        end
    end

`ifdef BTN_EVT_REPEAT_EN
    always_ff @(posedge clk_100Mhz or negedge rst) begin
        if (!rst) begin
            rep_flag <= 1'b0;
        end else begin
            rep_flag <= rep_flag_nxt;
        end
    end
`endif

endmodule

// File: doc/btn_event_ctrl.md
Name: btn_event_ctrl

Overview:
- Sequences a debounced button into discrete user events: short press, long press and double click. Each event is a one-cycle pulse.
- Sits between the debounce stage and consumers such as toggle/mode logic, so one physical button can drive several functions.
- All timing is counted in 1 ms tick strobes from the shared tick generator. No large counters run at 100 MHz.

Parameters:
- LONG_MS, 1000, ticks a press must be held to count as a long press (must be ≥2).
- DCLICK_MS, 300, ticks allowed after the first release for a second press to count as a double click (must be ≥1).
- REPEAT_MS, 200, tick period of long-press auto-repeat (used only when the optional feature is compiled in).
- CNT_W, 11, tick counter width. Must satisfy 2^CNT_W > max(LONG_MS, DCLICK_MS, REPEAT_MS).

Ports:
- clk_100Mhz  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle strobe, 1 kHz
- btn_db  in  1  debounced button level, 1 = pressed, synchronous to clk_100Mhz
- short_press  out  1  one-cycle pulse
- long_press  out  1  one-cycle pulse
- double_click  out  1  one-cycle pulse
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: while rst=0, state=IDLE, cnt=0, btn_q=0, and all outputs are 0. Reset takes effect immediately and asynchronously. Release is used synchronously. Reset mid-press drops the pending event with no pulse.
- Edges:
  - btn_q registers btn_db.
  - rise = btn_db & ~btn_q.
  - fall = ~btn_db & btn_q.
- Counter: cnt clears on every state transition and increments by 1 on tick within a state. It never wraps, because every state exits at or before its limit.
- States and transitions:
  - IDLE: on rise → PRESS1.
  - PRESS1:
    - fall → WAIT2.
    - Otherwise, when tick arrives and cnt==LONG_MS-1 → pulse long_press, go to HOLD.
    - If fall and that final tick occur in the same cycle, fall wins: no long_press, go to WAIT2.
  - WAIT2:
    - rise → pulse double_click, go to HOLD.
    - Otherwise, when tick arrives and cnt==DCLICK_MS-1 → pulse short_press, go to IDLE.
    - If rise and that final tick occur in the same cycle, rise wins: double_click only.
  - HOLD: on fall → IDLE. No pulse is emitted unless the optional feature is enabled.
- Pulses are registered and assert in the cycle after the qualifying edge/tick cycle. They are high for exactly one clock, and at most one pulse is high per cycle.
- Latencies:
  - short_press asserts DCLICK_MS ticks after release.
  - long_press asserts on the LONG_MS-th tick after the press edge.
- busy = (state != IDLE), registered.
- A tick stuck high causes cnt to advance every cycle. This is legal; behaviour is as specified with tick=1.

Optional Feature:
- Macro: BTN_EVT_REPEAT_EN.
- Defined: in HOLD, if entry to HOLD came from a long press, long_press re-pulses every REPEAT_MS ticks while btn_db stays high (cnt clears after each repeat). HOLD entered through double_click never repeats. A 1-bit flag records the entry path.
- Undefined: HOLD is purely a wait-for-release state. The REPEAT_MS parameter and the flag are not synthesized.

Decomposition:
- Package btn_evt_pkg holds:
  - state encoding localparams: IDLE=0, PRESS1=1, WAIT2=2, HOLD=3 (width 2);
  - an event code enum for debug: EVT_NONE, EVT_SHORT, EVT_LONG, EVT_DOUBLE.
- One sub-module, tick_counter: a CNT_W-bit counter with sync clear, tick-qualified increment, async active-low reset, and a terminal-compare output (cnt==LIMIT-1 && tick).
- The FSM and edge logic stay in btn_event_ctrl.

Test Plan (sim with LONG_MS=10, DCLICK_MS=4, REPEAT_MS=3, tick every 20 cycles):
- Press held for 3 ticks, then release and wait 6 ticks → exactly one short_press, 4 ticks after release; long_press and double_click stay 0; busy returns to 0.
- Press held for 12 ticks → one long_press on the 10th tick after the press; no short_press after release; busy drops the cycle after release is registered.
- Press 2 ticks, release, press again within 2 ticks → one double_click the cycle after the second rise; no short_press; hold then release → nothing further.
- Release coinciding with the 10th tick in PRESS1 → no long_press; short_press 4 ticks later. Second rise coinciding with the 4th WAIT2 tick → double_click only.
- Assert rst=0 mid-PRESS1 at tick 5 with btn_db held → all outputs 0 immediately. After release of rst with the button still held, no event occurs until a fresh rise.
- With BTN_EVT_REPEAT_EN, hold for 20 ticks → long_press at tick 10, then at ticks 13, 16 and 19; double_click followed by a hold → no repeats.
